// File: rtl/mem_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage
// and the SRAM controller. Read hits answer in the request cycle; misses and stores stall via mem_ready.
module mem_cache_controller #(
   parameter int          INDEX_BITS = 6,
   parameter logic [31:0] BASE_ADDR  = 32'd1024,
   parameter int          TAG_MSB    = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd_en,
   input  logic        mem_wr_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        sram_rd_en,
   output logic        sram_wr_en,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ready
);
   localparam int SETS  = 1 << INDEX_BITS;
   localparam int TAG_W = TAG_MSB - INDEX_BITS - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RD_MISS = 2'd1, WRITE = 2'd2} state_t;
   state_t r_state;

   logic [SETS-1:0]  r_valid [2];
   logic [SETS-1:0]  r_lru;
   logic [TAG_W-1:0] r_tag   [2][SETS];
   logic [31:0]      r_data  [2][SETS];

   logic [31:0]           w_offset;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [1:0]            w_hit;
   logic                  w_hit_any;
   logic                  w_hit_way;
   logic                  w_victim;
   logic                  w_active;
   logic                  w_done;
   logic                  w_fill;
   logic                  w_wr_hit;
   logic [31:0]           w_hit_data;
   logic                  w_unused;

   assign w_offset = mem_addr - BASE_ADDR;
   assign w_index  = w_offset[INDEX_BITS+1:2];
   assign w_tag    = w_offset[TAG_MSB:INDEX_BITS+2];
   assign w_unused = ^{w_offset[1:0], w_offset[31:TAG_MSB+1]};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_way
         assign w_hit[gi] = r_valid[gi][w_index] && (r_tag[gi][w_index] == w_tag);
      end
   endgenerate

   // A tag lives in at most one way, so way1's hit bit alone names the hit way.
   assign w_hit_any  = |w_hit;
   assign w_hit_way  = w_hit[1];
   assign w_hit_data = r_data[w_hit_way][w_index];
   assign w_victim   = !r_valid[0][w_index] ? 1'b0 :
                       !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];

   // Cache contents move only on the completing edge, so a stalled or abandoned access leaves no trace.
   assign w_active = mem_rd_en | mem_wr_en;
   assign w_done   = !rst && w_active && sram_ready;
   assign w_fill   = w_done && (r_state == RD_MISS);
   assign w_wr_hit = w_done && (r_state == WRITE) && w_hit_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_valid[0] <= '0;
         r_valid[1] <= '0;
         r_lru      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (mem_wr_en) begin
                  r_state <= WRITE;
               end else if (mem_rd_en) begin
                  if (w_hit_any) r_lru[w_index] <= ~w_hit_way;
                  else           r_state        <= RD_MISS;
               end
            end
            RD_MISS: begin
               if (!w_active) begin
                  r_state <= IDLE;
               end else if (sram_ready) begin
                  r_valid[w_victim][w_index] <= 1'b1;
                  r_lru[w_index]             <= ~w_victim;
                  r_state                    <= IDLE;
               end
            end
            WRITE: begin
               if (!w_active) begin
                  r_state <= IDLE;
               end else if (sram_ready) begin
                  if (w_hit_any) r_lru[w_index] <= ~w_hit_way;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_victim][w_index]  <= w_tag;
         r_data[w_victim][w_index] <= sram_rdata;
      end else if (w_wr_hit) begin
         r_data[w_hit_way][w_index] <= mem_wdata;
      end
   end

   assign sram_addr  = mem_addr;
   assign sram_wdata = mem_wdata;

   always_comb begin
      mem_ready  = 1'b1;
      mem_rdata  = 32'd0;
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (mem_wr_en) begin
                  mem_ready  = 1'b0;
                  sram_wr_en = 1'b1;
               end else if (mem_rd_en) begin
                  if (w_hit_any) begin
                     mem_rdata = w_hit_data;
                  end else begin
                     mem_ready  = 1'b0;
                     sram_rd_en = 1'b1;
                  end
               end
            end
            RD_MISS: begin
               if (w_active) begin
                  sram_rd_en = 1'b1;
                  mem_ready  = sram_ready;
                  if (sram_ready) mem_rdata = sram_rdata;
               end
            end
            WRITE: begin
               if (w_active) begin
                  sram_wr_en = 1'b1;
                  mem_ready  = sram_ready;
               end
            end
            default: mem_ready = 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_cache_controller.sv
// Self-checking bench for mem_cache_controller: directed scenarios plus random traffic
// compared against a per-set, per-way array model of the cache and a word-addressed SRAM model.
module tb_mem_cache_controller;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        sram_rd_en, sram_wr_en;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
   logic        sram_ready;

   int n_tests = 0;
   int n_fail  = 0;

   mem_cache_controller dut (
      .clk(clk), .rst(rst),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .sram_ready(sram_ready)
   );

   always #5 clk = ~clk;

   // Reference model: what each set holds, independent of how the RTL stores it.
   bit          m_valid [64][2];
   logic [31:0] m_tag   [64][2];
   logic [31:0] m_data  [64][2];
   bit          m_lru   [64];
   logic [31:0] smem [logic [31:0]];

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int set_of(input logic [31:0] a);
      return int'(((a - 32'd1024) >> 2) & 32'h3F);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return ((a - 32'd1024) >> 8) & 32'h7FF;
   endfunction

   function automatic int lookup(input logic [31:0] a);
      int s = set_of(a);
      for (int w = 0; w < 2; w++)
         if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
      return -1;
   endfunction

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      if (smem.exists(a)) return smem[a];
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         m_valid[s][0] = 1'b0;
         m_valid[s][1] = 1'b0;
         m_lru[s]      = 1'b0;
      end
   endtask

   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat,
                            output bit hit_seen, output logic [31:0] rdata_seen);
      int s = set_of(addr);
      int w = lookup(addr);
      int v;
      logic [31:0] exp_rd;
      @(negedge clk);
      mem_rd_en  = rd;
      mem_wr_en  = wr;
      mem_addr   = addr;
      mem_wdata  = wdata;
      sram_ready = !(wr || w < 0);
      sram_rdata = $urandom;
      #1;
      hit_seen   = mem_ready;
      rdata_seen = mem_rdata;
      check32("sram_addr", sram_addr, addr);
      if (wr) begin
         check32("wr_req_ready", 32'(mem_ready), 32'd0);
         check32("wr_req_sram_wr", 32'(sram_wr_en), 32'd1);
         check32("wr_req_sram_rd", 32'(sram_rd_en), 32'd0);
         check32("sram_wdata", sram_wdata, wdata);
         for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            sram_ready = (k == lat);
            #1;
            check32("wr_hold_sram_wr", 32'(sram_wr_en), 32'd1);
            check32("wr_hold_sram_rd", 32'(sram_rd_en), 32'd0);
            check32("wr_ready", 32'(mem_ready), 32'(sram_ready));
         end
         smem[addr] = wdata;
         if (w >= 0) begin
            m_data[s][w] = wdata;
            m_lru[s]     = (w == 0);
         end
      end else if (w >= 0) begin
         check32("rd_hit_ready", 32'(mem_ready), 32'd1);
         check32("rd_hit_data", mem_rdata, m_data[s][w]);
         check32("rd_hit_sram_rd", 32'(sram_rd_en), 32'd0);
         m_lru[s] = (w == 0);
      end else begin
         check32("rd_miss_ready", 32'(mem_ready), 32'd0);
         check32("rd_miss_sram_rd", 32'(sram_rd_en), 32'd1);
         exp_rd = sram_word(addr);
         for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            sram_ready = (k == lat);
            sram_rdata = (k == lat) ? exp_rd : $urandom;
            #1;
            check32("rd_hold_sram_rd", 32'(sram_rd_en), 32'd1);
            check32("rd_hold_sram_wr", 32'(sram_wr_en), 32'd0);
            check32("rd_ready", 32'(mem_ready), 32'(sram_ready));
            if (k == lat) begin
               check32("rd_miss_data", mem_rdata, exp_rd);
               rdata_seen = mem_rdata;
            end
         end
         v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : int'(m_lru[s]));
         m_valid[s][v] = 1'b1;
         m_tag[s][v]   = tag_of(addr);
         m_data[s][v]  = exp_rd;
         m_lru[s]      = (v == 0);
      end
      @(negedge clk);
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      sram_ready = 1'b1;
      #1;
      check32("idle_ready", 32'(mem_ready), 32'd1);
      check32("idle_sram_en", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
      $display("[TB] %s addr=0x%08h hit=%0d data=0x%08h", wr ? "WR" : "RD", addr, hit_seen,
               wr ? wdata : rdata_seen);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          h;
      logic [31:0] d;
      logic [31:0] a;
      int          op;

      rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      mem_addr = 32'h400; mem_wdata = 32'd0; sram_rdata = 32'd0; sram_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check32("reset_ready", 32'(mem_ready), 32'd1);
      check32("reset_rdata", mem_rdata, 32'd0);
      check32("reset_sram_en", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);

      // Read miss then same-cycle hit.
      do_access(1, 0, 32'h400, 32'd0, 2, h, d);
      check32("t1_miss", 32'(h), 32'd0);
      check32("t1_miss_data", d, sram_word(32'h400));
      do_access(1, 0, 32'h400, 32'd0, 0, h, d);
      check32("t1_hit", 32'(h), 32'd1);
      check32("t1_hit_data", d, sram_word(32'h400));

      // Store miss does not allocate.
      do_access(0, 1, 32'h404, 32'hDEADBEEF, 1, h, d);
      do_access(1, 0, 32'h404, 32'd0, 1, h, d);
      check32("t2_no_alloc", 32'(h), 32'd0);
      check32("t2_data", d, 32'hDEADBEEF);

      // LRU replacement within set 0.
      do_access(1, 0, 32'h500, 32'd0, 0, h, d);
      check32("t3_miss500", 32'(h), 32'd0);
      do_access(1, 0, 32'h400, 32'd0, 0, h, d);
      check32("t3_hit400", 32'(h), 32'd1);
      do_access(1, 0, 32'h600, 32'd0, 3, h, d);
      check32("t3_miss600", 32'(h), 32'd0);
      do_access(1, 0, 32'h400, 32'd0, 0, h, d);
      check32("t3_hit400_again", 32'(h), 32'd1);
      do_access(1, 0, 32'h500, 32'd0, 0, h, d);
      check32("t3_evicted500", 32'(h), 32'd0);

      // Store hit updates the cached word.
      do_access(0, 1, 32'h400, 32'h12345678, 2, h, d);
      do_access(1, 0, 32'h400, 32'd0, 0, h, d);
      check32("t4_hit", 32'(h), 32'd1);
      check32("t4_data", d, 32'h12345678);

      // Both enables: store path only.
      do_access(1, 1, 32'h408, 32'hCAFEF00D, 2, h, d);
      do_access(1, 0, 32'h408, 32'd0, 0, h, d);
      check32("t5_no_alloc", 32'(h), 32'd0);
      check32("t5_data", d, 32'hCAFEF00D);

      // Abandoned read miss leaves the cache untouched.
      @(negedge clk);
      mem_rd_en = 1'b1; mem_addr = 32'h0003_0400; sram_ready = 1'b0;
      @(negedge clk);
      mem_rd_en = 1'b0; sram_ready = 1'b1;
      #1;
      check32("abandon_ready", 32'(mem_ready), 32'd1);
      check32("abandon_sram_en", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
      do_access(1, 0, 32'h0003_0400, 32'd0, 0, h, d);
      check32("abandon_no_fill", 32'(h), 32'd0);

      // Reset in the middle of a read miss.
      @(negedge clk);
      mem_rd_en = 1'b1; mem_addr = 32'h0002_0400; sram_ready = 1'b0;
      #1;
      check32("t6_req_sram_rd", 32'(sram_rd_en), 32'd1);
      @(negedge clk);
      #1;
      check32("t6_hold_sram_rd", 32'(sram_rd_en), 32'd1);
      @(negedge clk);
      rst = 1'b1; mem_rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0; sram_ready = 1'b1;
      #1;
      model_reset();
      check32("t6_ready", 32'(mem_ready), 32'd1);
      check32("t6_sram_en", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
      do_access(1, 0, 32'h400, 32'd0, 1, h, d);
      check32("t6_miss_after_rst", 32'(h), 32'd0);
      check32("t6_data", d, 32'h12345678);

      // Random traffic over 4 sets x 4 tags to force conflicts and evictions.
      for (int i = 0; i < 150; i++) begin
         a  = 32'd1024 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 2);
         op = $urandom_range(0, 9);
         do_access(op != 6 && op != 7 && op != 8, op >= 6, a, $urandom, $urandom_range(0, 3), h, d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
